dg_pc_stack_unit: RTL and testbench

Parametrised program-counter and return-stack unit for the DG00xx 4-bit controller family.
- Generalises the fixed 10-bit polynomial PC and 4-deep shift-register stack to configurable page/offset widths, stack depth, LFSR taps and call page.
- Adds a pending far-page register, depth tracking and sticky overflow/underflow flags.
- Sits between the instruction decoder (drives op/adv) and the ROM address mux (consumes pc).

---
 rtl/dg_pc_stack_unit.sv | 107 ++++++++++
 tb/tb_dg_pc_stack_unit.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/dg_pc_stack_unit.sv
// Program counter (LFSR-sequenced in-page offset + page) with return stack for DG00xx controllers.
// Optional: define DG_PC_LOCKUP_RECOVER_EN to escape the all-ones offset lock-up state.
module dg_pc_stack_unit #(
    parameter int                PL_W      = 6,
    parameter int                PU_W      = 4,
    parameter int                DEPTH     = 4,
    parameter logic [PL_W-1:0]   TAP       = 6'b000011,
    parameter logic [PU_W-1:0]   CALL_PAGE = 4'b1111,
    localparam int               DW        = $clog2(DEPTH+1)
) (
    input  logic                 clk_in,
    input  logic                 RESET,
    input  logic                 adv,
    input  logic [2:0]           op,
    input  logic [PL_W-1:0]      tgt,
    input  logic [PU_W-1:0]      page_in,
    input  logic                 clr_flags,
    output logic [PU_W+PL_W-1:0] pc,
    output logic [DW-1:0]        depth,
    output logic                 ovf,
    output logic                 unf,
    output logic                 page_pend
);
    localparam logic [2:0] OP_JMP     = 3'd1;
    localparam logic [2:0] OP_CALL    = 3'd2;
    localparam logic [2:0] OP_RET     = 3'd3;
    localparam logic [2:0] OP_SETPAGE = 3'd4;

    logic [PL_W-1:0]      pl;
    logic [PU_W-1:0]      pu;
    logic [PU_W-1:0]      pend_pg;
    logic [PU_W+PL_W-1:0] stack [DEPTH];
    logic [PL_W-1:0]      pl_succ;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;

    // Sequential successor; the recovery build maps the all-ones fixed point to zero.
    always_comb begin
        pl_succ = {~^(pl & TAP), pl[PL_W-1:1]};
`ifdef DG_PC_LOCKUP_RECOVER_EN
        if (&pl)
            pl_succ = '0;
`endif
    end

    assign full  = (depth == DW'(DEPTH));
    assign empty = (depth == '0);
    assign push  = (op == OP_CALL);
    assign pop   = (op == OP_RET);
    assign pc    = {pu, pl};

    always_ff @(posedge clk_in or negedge RESET) begin
        if (!RESET) begin
            pl        <= '0;
            pu        <= '0;
            pend_pg   <= '0;
            depth     <= '0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
            page_pend <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                stack[i] <= '0;
        end else begin
            // Setting events take precedence over a same-cycle clear.
            ovf <= (ovf & ~clr_flags) | (push & full);
            unf <= (unf & ~clr_flags) | (pop & empty);
            case (op)
                OP_JMP: begin
                    pl        <= tgt;
                    page_pend <= 1'b0;
                    if (page_pend)
                        pu <= pend_pg;
                end
                OP_CALL: begin
                    pl        <= tgt;
                    pu        <= page_pend ? pend_pg : CALL_PAGE;
                    page_pend <= 1'b0;
                    stack[0]  <= {pu, pl_succ};
                    for (int i = 1; i < DEPTH; i++)
                        stack[i] <= stack[i-1];
                    if (!full)
                        depth <= depth + 1'b1;
                end
                OP_RET: begin
                    {pu, pl} <= stack[0];
                    // Bottom entry keeps its value, so over-popping returns a stale duplicate.
                    for (int i = 0; i < DEPTH-1; i++)
                        stack[i] <= stack[i+1];
                    if (!empty)
                        depth <= depth - 1'b1;
                end
                OP_SETPAGE: begin
                    pend_pg   <= page_in;
                    page_pend <= 1'b1;
                    if (adv)
                        pl <= pl_succ;
                end
                default: begin
                    if (adv)
                        pl <= pl_succ;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dg_pc_stack_unit.sv
// Directed self-checking bench for dg_pc_stack_unit with default parameters.
module tb_dg_pc_stack_unit;
    logic       clk_in = 1'b0;
    logic       RESET;
    logic       adv;
    logic [2:0] op;
    logic [5:0] tgt;
    logic [3:0] page_in;
    logic       clr_flags;
    logic [9:0] pc;
    logic [2:0] depth;
    logic       ovf, unf, page_pend;

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [2:0] NOP = 3'd0, JMP = 3'd1, CALL = 3'd2, RET = 3'd3, SETPG = 3'd4;

    dg_pc_stack_unit dut (
        .clk_in(clk_in), .RESET(RESET), .adv(adv), .op(op), .tgt(tgt),
        .page_in(page_in), .clr_flags(clr_flags), .pc(pc), .depth(depth),
        .ovf(ovf), .unf(unf), .page_pend(page_pend)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [2:0] o, input logic [5:0] t, input logic a,
                        input logic [3:0] p, input logic c);
        op = o; tgt = t; adv = a; page_in = p; clr_flags = c;
        @(posedge clk_in);
        #1;
        op = NOP; adv = 1'b0; clr_flags = 1'b0;
    endtask

    initial begin
        RESET = 1'b0; adv = 1'b0; op = NOP; tgt = '0; page_in = '0; clr_flags = 1'b0;
        #12;
        chk("rst_pc", 16'(pc), 16'h000);
        chk("rst_depth", 16'(depth), 16'd0);
        chk("rst_flags", 16'({ovf, unf, page_pend}), 16'd0);
        @(posedge clk_in); #1;
        RESET = 1'b1;

        // Sequential LFSR advance
        step(NOP, 6'h00, 1'b1, 4'h0, 1'b0); chk("adv1", 16'(pc), 16'h020);
        step(NOP, 6'h00, 1'b1, 4'h0, 1'b0); chk("adv2", 16'(pc), 16'h030);
        step(NOP, 6'h00, 1'b1, 4'h0, 1'b0); chk("adv3", 16'(pc), 16'h038);

        // CALL / RET round trip
        step(CALL, 6'h05, 1'b0, 4'h0, 1'b0);
        chk("call_pc", 16'(pc), 16'h3C5);
        chk("call_depth", 16'(depth), 16'd1);
        step(RET, 6'h00, 1'b0, 4'h0, 1'b0);
        chk("ret_pc", 16'(pc), 16'h03C);
        chk("ret_depth", 16'(depth), 16'd0);
        chk("ret_unf", 16'(unf), 16'd0);

        // Far jump via pending page
        step(SETPG, 6'h00, 1'b0, 4'h3, 1'b0);
        chk("setpg_pend", 16'(page_pend), 16'd1);
        chk("setpg_pc", 16'(pc), 16'h03C);
        step(JMP, 6'h11, 1'b0, 4'h0, 1'b0);
        chk("fjmp_pc", 16'(pc), 16'h0D1);
        chk("fjmp_pend", 16'(page_pend), 16'd0);
        step(JMP, 6'h02, 1'b0, 4'h0, 1'b0);
        chk("njmp_pc", 16'(pc), 16'h0C2);

        // Overflow: five pushes into four entries
        step(CALL, 6'h01, 1'b0, 4'h0, 1'b0); chk("c1_pc", 16'(pc), 16'h3C1);
        step(CALL, 6'h02, 1'b0, 4'h0, 1'b0); chk("c2_pc", 16'(pc), 16'h3C2);
        step(CALL, 6'h04, 1'b0, 4'h0, 1'b0); chk("c3_pc", 16'(pc), 16'h3C4);
        step(CALL, 6'h08, 1'b0, 4'h0, 1'b0);
        chk("c4_depth", 16'(depth), 16'd4);
        chk("c4_ovf", 16'(ovf), 16'd0);
        step(CALL, 6'h10, 1'b0, 4'h0, 1'b0);
        chk("c5_pc", 16'(pc), 16'h3D0);
        chk("c5_depth", 16'(depth), 16'd4);
        chk("c5_ovf", 16'(ovf), 16'd1);
        step(RET, 6'h00, 1'b0, 4'h0, 1'b0); chk("r1_pc", 16'(pc), 16'h3E4); chk("r1_depth", 16'(depth), 16'd3);
        step(RET, 6'h00, 1'b0, 4'h0, 1'b0); chk("r2_pc", 16'(pc), 16'h3E2);
        step(RET, 6'h00, 1'b0, 4'h0, 1'b0); chk("r3_pc", 16'(pc), 16'h3C1);
        step(RET, 6'h00, 1'b0, 4'h0, 1'b0);
        chk("r4_pc", 16'(pc), 16'h3C0);
        chk("r4_depth", 16'(depth), 16'd0);
        chk("r4_unf", 16'(unf), 16'd0);
        step(RET, 6'h00, 1'b0, 4'h0, 1'b0);
        chk("r5_pc", 16'(pc), 16'h3C0);
        chk("r5_depth", 16'(depth), 16'd0);
        chk("r5_flags", 16'({ovf, unf}), 16'b11);
        step(NOP, 6'h00, 1'b0, 4'h0, 1'b1);
        chk("clr_flags", 16'({ovf, unf}), 16'b00);
        chk("clr_pc", 16'(pc), 16'h3C0);
        step(RET, 6'h00, 1'b0, 4'h0, 1'b1);
        chk("clr_vs_set", 16'(unf), 16'd1);
        step(NOP, 6'h00, 1'b0, 4'h0, 1'b1);
        chk("clr_again", 16'(unf), 16'd0);

        // adv priority against ops
        step(CALL, 6'h07, 1'b1, 4'h0, 1'b0);
        chk("advcall_pc", 16'(pc), 16'h3C7);
        step(RET, 6'h00, 1'b1, 4'h0, 1'b0);
        chk("advcall_ret", 16'(pc), 16'h3E0);
        step(SETPG, 6'h00, 1'b1, 4'h5, 1'b0);
        chk("advsetpg_pc", 16'(pc), 16'h3F0);
        chk("advsetpg_pend", 16'(page_pend), 16'd1);
        step(CALL, 6'h09, 1'b0, 4'h0, 1'b0);
        chk("fcall_pc", 16'(pc), 16'h149);
        chk("fcall_pend", 16'(page_pend), 16'd0);
        step(RET, 6'h00, 1'b0, 4'h0, 1'b0);
        chk("fcall_ret", 16'(pc), 16'h3F8);
        step(SETPG, 6'h00, 1'b0, 4'h6, 1'b0);
        step(SETPG, 6'h00, 1'b0, 4'h2, 1'b0);
        step(JMP, 6'h00, 1'b0, 4'h0, 1'b0);
        chk("setpg_ovwr", 16'(pc), 16'h080);

        // All-ones offset
        step(JMP, 6'h3F, 1'b0, 4'h0, 1'b0);
        chk("lock_jmp", 16'(pc), 16'h0BF);
        step(CALL, 6'h00, 1'b0, 4'h0, 1'b0);
        chk("lock_call", 16'(pc), 16'h3C0);
        step(RET, 6'h00, 1'b0, 4'h0, 1'b0);
`ifdef DG_PC_LOCKUP_RECOVER_EN
        chk("lock_ret", 16'(pc), 16'h080);
`else
        chk("lock_ret", 16'(pc), 16'h0BF);
`endif
        step(JMP, 6'h3F, 1'b0, 4'h0, 1'b0);
        step(NOP, 6'h00, 1'b1, 4'h0, 1'b0);
`ifdef DG_PC_LOCKUP_RECOVER_EN
        chk("lock_adv", 16'(pc), 16'h080);
`else
        chk("lock_adv", 16'(pc), 16'h0BF);
`endif

        // Asynchronous reset with a CALL in flight
        step(CALL, 6'h01, 1'b0, 4'h0, 1'b0);
        step(SETPG, 6'h00, 1'b0, 4'h9, 1'b0);
        chk("pre_rst_depth", 16'(depth), 16'd1);
        op = CALL; tgt = 6'h22;
        #2;
        RESET = 1'b0;
        #1;
        chk("arst_pc", 16'(pc), 16'h000);
        chk("arst_depth", 16'(depth), 16'd0);
        chk("arst_pend", 16'(page_pend), 16'd0);
        @(posedge clk_in); #1;
        chk("arst_hold_pc", 16'(pc), 16'h000);
        RESET = 1'b1;
        op = NOP;
        step(NOP, 6'h00, 1'b0, 4'h0, 1'b0);
        chk("post_rst_pc", 16'(pc), 16'h000);
        chk("post_rst_flags", 16'({depth, ovf, unf, page_pend}), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
